wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 64, data width of each write-back value and of wr_data.
REQ-002 Parameter NREG, default 32, number of architectural registers; address width is 5.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, reset, asynchronous and active-low (0 = reset asserted).
REQ-005 Port req_valid, input, 3, per-source write-back request; bit i = source i (0 ALU, 1 load, 2 mul/div/CSR).
REQ-006 Port req_ready, output, 3, per-source grant/acceptance.
REQ-007 Port req_addr, input, 15, destination register per source; source i at bits [5i+4:5i].
REQ-008 Port req_data, input, 3*XLEN, write data per source; source i at bits [XLEN*i+XLEN-1:XLEN*i].
REQ-009 Port busy_set_en, input, 1, issue stage marks a destination register pending.
REQ-010 Port busy_set_addr, input, 5, register to mark pending.
REQ-011 Port rs1_addr / rs2_addr, input, 5 each, scoreboard query addresses.
REQ-012 Port rs1_busy / rs2_busy, output, 1 each, pending status of the queried registers.
REQ-013 Port busy_vec, output, NREG, full scoreboard state.
REQ-014 Port wr_en / wr_addr / wr_data, output, 1 / 5 / XLEN, registered register-file write port.

Function
REQ-015 Arbitration SHALL be round-robin over sources with req_valid=1; search starts at (last_grant+1) mod 3.
REQ-016 req_ready SHALL be combinational, one-hot or zero, and asserted only for the granted valid source.
REQ-017 A transfer SHALL occur when req_valid[i] and req_ready[i] are both 1 at a rising edge.
REQ-018 last_grant SHALL update to the granted index only on a transfer; with no transfer it SHALL hold.
REQ-019 Requesters SHALL hold valid, addr and data stable until accepted; the block SHALL NOT check this.
REQ-020 On a transfer, wr_addr and wr_data SHALL take the source's values at that edge (latency 1 cycle).
REQ-021 On a transfer, wr_en SHALL take 1 at the same edge if req_addr != 0, otherwise 0.
REQ-022 A transfer to x0 SHALL still complete its handshake but is discarded.
REQ-023 With no transfer, wr_en SHALL be 0 at the next edge; wr_addr and wr_data SHALL hold.
REQ-024 Back-to-back transfers SHALL be sustained at one per cycle with no bubble.
REQ-025 Scoreboard: busy_set_en=1 with busy_set_addr != 0 SHALL set busy_vec[busy_set_addr] at the edge.
REQ-026 A registered wr_en=1 SHALL clear busy_vec[wr_addr] at the next edge, coincident with the register-file write.
REQ-027 If a set and a clear target the same register at the same edge, set SHALL win.
REQ-028 busy_vec[0] SHALL be constant 0; busy_set_addr=0 SHALL be ignored.
REQ-029 rs1_busy SHALL equal busy_vec[rs1_addr] combinationally; rs2_busy SHALL equal busy_vec[rs2_addr] combinationally.
REQ-030 Clearing an already-clear bit, or setting an already-set bit, SHALL be a no-op with no error.

Reset
REQ-031 While rst=0: wr_en=0, wr_addr=0, wr_data=0, busy_vec=0 and last_grant=2, all asynchronously.
REQ-032 While rst=0, req_ready SHALL be 0.
REQ-033 Reset mid-operation SHALL drop any accepted-but-unwritten write and all pending bits.
REQ-034 After rst rises, the first grant SHALL prefer source 0.

Verification
REQ-035 Reset, then req_valid=3'b111 held for 3 cycles: req_ready sequence is 001, 010, 100; wr_en is 1 for 3 consecutive cycles, one cycle later than the matching grant.
REQ-036 Source 1 sends addr=5, data=64'hDEAD_BEEF: wr_en=1, wr_addr=5, wr_data=64'hDEAD_BEEF in the next cycle; then wr_en=0.
REQ-037 Source 2 sends addr=0: req_ready[2]=1, wr_en stays 0, and busy_vec is unchanged.
REQ-038 Set busy for x7, then a write to x7 is accepted: rs1_addr=7 gives rs1_busy=1 until the edge where wr_en=1 commits, then 0 from the following cycle.
REQ-039 busy_set for x9 at the same edge as a committed write to x9: busy_vec[9] remains 1.
REQ-040 Assert rst=0 asynchronously between edges while wr_en=1 and busy_vec is nonzero: wr_en and busy_vec go to 0 immediately without a clock edge.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin selection among three execution sources,
// a registered register-file write port, and a pending-register scoreboard
// that is set at issue and cleared when the write-back commits.
module wb_arbiter #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req_valid,
    output logic [2:0]          req_ready,
    input  logic [14:0]         req_addr,
    input  logic [3*XLEN-1:0]   req_data,
    input  logic                busy_set_en,
    input  logic [4:0]          busy_set_addr,
    input  logic [4:0]          rs1_addr,
    input  logic [4:0]          rs2_addr,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic [NREG-1:0]     busy_vec,
    output logic                wr_en,
    output logic [4:0]          wr_addr,
    output logic [XLEN-1:0]     wr_data
);

    // Next source index in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] rr_step(input logic [1:0] base);
        logic [1:0] nxt;
        case (base)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // Scoreboard read; addresses beyond NREG report not-busy.
    function automatic logic busy_lookup(input logic [NREG-1:0] vec, input logic [4:0] addr);
        logic hit;
        hit = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (addr == 5'(r)) begin
                hit = vec[r];
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    logic [1:0]        last_grant_q, last_grant_d;
    logic              wr_en_q, wr_en_d;
    logic [4:0]        wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic [1:0]        cand_s;
    logic [1:0]        grant_idx_s;
    logic              grant_found_s;
    logic [2:0]        req_ready_s;
    logic              xfer_s;
    logic [4:0]        sel_addr_s;
    logic [XLEN-1:0]   sel_data_s;

    // Round-robin search starting one past the last granted source.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = 2'd0;
        cand_s        = rr_step(last_grant_q);
        for (int k = 0; k < 3; k++) begin
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                cand_s = rr_step(cand_s);
            end
        end
    end

    // One-hot acceptance for the winner; nothing is accepted while in reset.
    always_comb begin
        req_ready_s = 3'b000;
        if (rst && grant_found_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = 3'b000;
        end
    end

    assign xfer_s     = rst & grant_found_s;
    assign sel_addr_s = req_addr[int'(grant_idx_s) * 5 +: 5];
    assign sel_data_s = req_data[int'(grant_idx_s) * XLEN +: XLEN];

    // Write port and grant pointer: capture the winner, hold when idle.
    always_comb begin
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        if (xfer_s) begin
            last_grant_d = grant_idx_s;
            wr_en_d      = (sel_addr_s != 5'd0);
            wr_addr_d    = sel_addr_s;
            wr_data_d    = sel_data_s;
        end else begin
            wr_en_d      = 1'b0;
        end
    end

    // Scoreboard update: commit clears first, issue sets override; x0 never busy.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (wr_en_q && (wr_addr_q == 5'(r))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
            if (busy_set_en && (busy_set_addr == 5'(r))) begin
                busy_d[r] = 1'b1;
            end else begin
                busy_d[r] = busy_d[r];
            end
        end
        busy_d[0] = 1'b0;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= 2'd2;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 5'd0;
            wr_data_q    <= {XLEN{1'b0}};
            busy_q       <= {NREG{1'b0}};
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready = req_ready_s;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy_vec  = busy_q;
    assign rs1_busy  = busy_lookup(busy_q, rs1_addr);
    assign rs2_busy  = busy_lookup(busy_q, rs2_addr);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected write-back results are queued when
// a request is driven and compared one cycle later when the port updates.
module tb_wb_arbiter;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    logic              clk;
    logic              rst;
    logic [2:0]        req_valid;
    logic [2:0]        req_ready;
    logic [14:0]       req_addr;
    logic [3*XLEN-1:0] req_data;
    logic              busy_set_en;
    logic [4:0]        busy_set_addr;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;
    logic [NREG-1:0]   busy_vec;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [XLEN-1:0]   wr_data;

    typedef struct packed {
        logic            en;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wb_t;

    wb_t             sb[$];
    int              n_cmp;
    int              n_err;
    logic [4:0]      hold_addr;
    logic [XLEN-1:0] hold_data;
    logic [NREG-1:0] exp_busy;

    wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .busy_vec(busy_vec),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests (called at posedge+1), check the grant,
    // queue the expected write-back, then compare it after the edge.
    task automatic cycle(input logic [2:0] v, input logic [2:0] exp_rdy,
                         input logic set_en, input logic [4:0] set_addr);
        wb_t e;
        int  idx;
        req_valid     = v;
        busy_set_en   = set_en;
        busy_set_addr = set_addr;
        #1;
        chk("req_ready", XLEN'(req_ready), XLEN'(exp_rdy));
        idx = (exp_rdy == 3'b010) ? 1 : ((exp_rdy == 3'b100) ? 2 : 0);
        if (exp_rdy != 3'b000) begin
            hold_addr = req_addr[idx*5 +: 5];
            hold_data = req_data[idx*XLEN +: XLEN];
            e.en      = (hold_addr != 5'd0);
        end else begin
            e.en      = 1'b0;
        end
        e.addr = hold_addr;
        e.data = hold_data;
        sb.push_back(e);
        @(posedge clk);
        #1;
        busy_set_en = 1'b0;
        req_valid   = 3'b000;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("wr_en",   XLEN'(wr_en),   XLEN'(e.en));
            chk("wr_addr", XLEN'(wr_addr), XLEN'(e.addr));
            chk("wr_data", wr_data,        e.data);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0;
        n_cmp = 0; n_err = 0;
        hold_addr = 5'd0; hold_data = {XLEN{1'b0}}; exp_busy = {NREG{1'b0}};
        req_valid = 3'b111; req_addr = {5'd3, 5'd2, 5'd1};
        req_data = {64'h3333_0000_0000_0003, 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
        busy_set_en = 1'b0; busy_set_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;

        // Reset state, including no acceptance while held in reset.
        #3;
        chk("rst_wr_en",    XLEN'(wr_en),     '0);
        chk("rst_wr_addr",  XLEN'(wr_addr),   '0);
        chk("rst_wr_data",  wr_data,          '0);
        chk("rst_busy_vec", XLEN'(busy_vec),  '0);
        chk("rst_ready",    XLEN'(req_ready), '0);
        @(posedge clk); #1; rst = 1'b1;

        // All three requesting: 001, 010, 100, writes back-to-back.
        cycle(3'b111, 3'b001, 1'b0, 5'd0);
        cycle(3'b111, 3'b010, 1'b0, 5'd0);
        cycle(3'b111, 3'b100, 1'b0, 5'd0);
        cycle(3'b000, 3'b000, 1'b0, 5'd0);

        // Load source writes x5.
        req_addr = {5'd0, 5'd5, 5'd0};
        req_data = {64'h0, 64'hDEAD_BEEF, 64'h0};
        cycle(3'b010, 3'b010, 1'b0, 5'd0);
        cycle(3'b000, 3'b000, 1'b0, 5'd0);

        // Write to x0 completes handshake but does not write or touch busy bits.
        cycle(3'b000, 3'b000, 1'b1, 5'd3);
        exp_busy[3] = 1'b1;
        chk("busy_set_x3", XLEN'(busy_vec), XLEN'(exp_busy));
        req_addr = {5'd0, 5'd0, 5'd0};
        req_data = {64'hCAFE_0000_0000_0002, 64'h0, 64'h0};
        cycle(3'b100, 3'b100, 1'b0, 5'd0);
        chk("x0_busy_unch", XLEN'(busy_vec), XLEN'(exp_busy));

        // Busy on x7 persists through the commit cycle, then clears.
        rs1_addr = 5'd7;
        cycle(3'b000, 3'b000, 1'b1, 5'd7);
        chk("rs1_busy_set", XLEN'(rs1_busy), 64'd1);
        req_addr = {5'd0, 5'd0, 5'd7};
        req_data = {64'h0, 64'h0, 64'h7777_7777_7777_7777};
        cycle(3'b001, 3'b001, 1'b0, 5'd0);
        chk("rs1_busy_commit", XLEN'(rs1_busy), 64'd1);
        cycle(3'b000, 3'b000, 1'b0, 5'd0);
        chk("rs1_busy_clear", XLEN'(rs1_busy), 64'd0);
        chk("busy_after_x7", XLEN'(busy_vec), XLEN'(exp_busy));

        // Set and clear of x9 at the same edge: set wins.
        rs2_addr = 5'd9;
        req_addr = {5'd0, 5'd9, 5'd0};
        req_data = {64'h0, 64'h9999_0000_0000_0009, 64'h0};
        cycle(3'b010, 3'b010, 1'b0, 5'd0);
        cycle(3'b000, 3'b000, 1'b1, 5'd9);
        exp_busy[9] = 1'b1;
        chk("rs2_busy_set_wins", XLEN'(rs2_busy), 64'd1);
        chk("busy_vec_x9", XLEN'(busy_vec), XLEN'(exp_busy));

        // Setting x0 is ignored.
        cycle(3'b000, 3'b000, 1'b1, 5'd0);
        chk("busy_x0_ignored", XLEN'(busy_vec), XLEN'(exp_busy));

        // Partial request set rotates correctly.
        req_addr = {5'd13, 5'd0, 5'd12};
        req_data = {64'hD000_0000_0000_000D, 64'h0, 64'hC000_0000_0000_000C};
        cycle(3'b101, 3'b100, 1'b0, 5'd0);
        cycle(3'b101, 3'b001, 1'b0, 5'd0);

        // Asynchronous reset mid-cycle while a write is pending on the port.
        req_addr = {5'd0, 5'd11, 5'd0};
        req_data = {64'h0, 64'hBBBB_0000_0000_000B, 64'h0};
        cycle(3'b010, 3'b010, 1'b0, 5'd0);
        chk("pre_rst_busy", XLEN'(busy_vec), XLEN'(exp_busy));
        req_valid = 3'b111;
        #2;
        rst = 1'b0;
        #1;
        chk("async_wr_en",   XLEN'(wr_en),     '0);
        chk("async_busy",    XLEN'(busy_vec),  '0);
        chk("async_wr_addr", XLEN'(wr_addr),   '0);
        chk("async_wr_data", wr_data,          '0);
        chk("async_ready",   XLEN'(req_ready), '0);
        exp_busy = {NREG{1'b0}};
        hold_addr = 5'd0; hold_data = {XLEN{1'b0}};
        @(posedge clk); #1; rst = 1'b1;

        // First grant after reset goes to source 0.
        req_addr = {5'd3, 5'd2, 5'd1};
        req_data = {64'h3, 64'h2, 64'h1};
        cycle(3'b111, 3'b001, 1'b0, 5'd0);
        cycle(3'b000, 3'b000, 1'b0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
